// File: rtl/delay_ctrl_defs.sv
// Shared definitions for the delay-path controllers: FSM encodings and the
// default latency-field width.
package delay_ctrl_defs;
    localparam int LW_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first set request
// found when searching from ptr upward with wrap-around.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/delay_arb_ctrl.sv
// Shares one delay resource among NREQ requesters: round-robin accept, count
// down the requested latency, then emit a one-cycle completion pulse.
module delay_arb_ctrl
    import delay_ctrl_defs::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int LW   = LW_DEF,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_val,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [NREQ*LW-1:0]   req_lat,
    input  logic [NREQ*W-1:0]    req_data,
    input  logic                 flush,
    output logic                 resp_val,
    output logic [IW-1:0]        resp_id,
    output logic [W-1:0]         resp_data,
    output logic                 busy
);
    state_t          state, next_state;
    logic [LW-1:0]   cnt;
    logic [IW-1:0]   ptr, gnt_id, lat_id;
    logic [W-1:0]    lat_data, acc_data;
    logic [LW-1:0]   acc_lat, eff_lat;
    logic [NREQ-1:0] gnt;
    logic            accept, resp_q, wait_done;

    rr_arbiter #(.N(NREQ), .PW(IW)) u_arb (
        .req (req_val),
        .ptr (ptr),
        .gnt (gnt)
    );

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i]) gnt_id = IW'(i);
    end

    assign acc_lat = req_lat[gnt_id*LW +: LW];
    assign acc_data = req_data[gnt_id*W +: W];
    assign eff_lat = (acc_lat == '0) ? LW'(1) : acc_lat;

    // Gating with reset keeps req_rdy low while reset is held.
    assign req_rdy = (state == IDLE && !flush && reset) ? gnt : '0;
    assign accept = |req_rdy;
    assign wait_done = (state == WAIT) && !flush && (cnt == LW'(1));
    assign busy = (state != IDLE);

    // resp_q is only ever high in DONE; a flush in that cycle masks the pulse.
    assign resp_val = resp_q & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = (eff_lat == LW'(1)) ? DONE : WAIT;
            WAIT: begin
                if (flush)                next_state = IDLE;
                else if (cnt == LW'(1))   next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            ptr       <= '0;
            lat_id    <= '0;
            lat_data  <= '0;
            resp_q    <= 1'b0;
            resp_id   <= '0;
            resp_data <= '0;
        end else begin
            resp_q <= (next_state == DONE);
            if (accept) begin
                ptr      <= (gnt_id == IW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
                lat_id   <= gnt_id;
                lat_data <= acc_data;
                cnt      <= eff_lat - 1'b1;
            end else if (state == WAIT) begin
                cnt <= flush ? '0 : cnt - 1'b1;
            end
            if (accept && eff_lat == LW'(1)) begin
                resp_id   <= gnt_id;
                resp_data <= acc_data;
            end else if (wait_done) begin
                resp_id   <= lat_id;
                resp_data <= lat_data;
            end
        end
    end
endmodule
